// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: deserialises an idle-high 8N1 line into bytes on a
// valid/ready handshake, with one-cycle framing and overrun error pulses.
`timescale 1ns/1ps
module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_framing_err,
  output logic       rx_overrun,
  output logic       rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          sync1, line;
  logic [CW-1:0] ctr;
  logic [2:0]    bitn;
  logic [7:0]    shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= midi_in;
      line  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= WAIT_IDLE;
      ctr            <= '0;
      bitn           <= '0;
      shreg          <= '0;
      rx_data        <= 8'h00;
      rx_valid       <= 1'b0;
      rx_framing_err <= 1'b0;
      rx_overrun     <= 1'b0;
      rx_busy        <= 1'b1;
    end else begin
      rx_framing_err <= 1'b0;
      rx_overrun     <= 1'b0;
      // a delivery later in this block overrides the accept clear
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (line) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        IDLE: begin
          if (!line) begin
            state   <= START;
            ctr     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (ctr == HALF_M1) begin
            ctr  <= '0;
            bitn <= '0;
            if (line) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        DATA: begin
          if (ctr == FULL_M1) begin
            ctr   <= '0;
            shreg <= {line, shreg[7:1]};
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        STOP: begin
          if (ctr == FULL_M1) begin
            ctr <= '0;
            // leaving at mid-stop-bit lets the next start edge be caught
            if (line) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              state          <= WAIT_IDLE;
              rx_framing_err <= 1'b1;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        default: begin
          state   <= WAIT_IDLE;
          rx_busy <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: serial stimulus with a byte scoreboard popped on
// every accepted handshake, plus per-scenario checks.
`timescale 1ns/1ps
module tb_midi_uart_rx;
  localparam int CPB = 32;

  logic       clk = 1'b0, rst = 1'b1, midi_in = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_framing_err, rx_overrun, rx_busy;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, n_fe = 0, n_ov = 0, n_both = 0, rise_cyc = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] sb[$];

  midi_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .midi_in(midi_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_framing_err(rx_framing_err), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: sampled on the falling edge, so rx_ready/rx_valid here are what
  // the next rising edge sees
  always @(negedge clk) begin
    if (rx_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    prev_valid = rx_valid;
    if (rx_framing_err) n_fe++;
    if (rx_overrun) n_ov++;
    if (rx_framing_err && rx_overrun) n_both++;
    if (rx_valid && rx_ready) begin
      n_checks++;
      n_acc++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got byte %h, expected none", rx_data);
      end else begin
        exp_b = sb.pop_front();
        if (rx_data !== exp_b) begin
          n_fail++;
          $display("FAIL sb_data: got %h, expected %h", rx_data, exp_b);
        end
      end
    end
  end

  task automatic bit_time(input logic v);
    midi_in = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    midi_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stopb);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(stopb);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", rx_valid); end
    n_checks++; if (rx_framing_err !== 1'b0) begin n_fail++; $display("FAIL rst_fe: got %b, expected 0", rx_framing_err); end
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got %b, expected 0", rx_overrun); end
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b, expected 1", rx_busy); end
    rst = 1'b0;
    idle(4);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b, expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int t0, a0;
    rx_ready = 1'b1;
    rise_cyc = -1;
    a0 = n_acc;
    sb.push_back(8'h90);
    sb.push_back(8'h3C);
    t0 = cyc;
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(2*CPB);
    n_checks++;
    if (rise_cyc - t0 < 305 || rise_cyc - t0 > 309) begin
      n_fail++; $display("FAIL b2b_latency: got %0d clk, expected 307+/-2", rise_cyc - t0);
    end
    n_checks++; if (n_acc - a0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d bytes, expected 2", n_acc - a0); end
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL b2b_left: got %0d pending, expected 0", sb.size()); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b, expected 0", rx_valid); end
  endtask

  task automatic test_glitch;
    int a0, f0, o0;
    a0 = n_acc; f0 = n_fe; o0 = n_ov;
    midi_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    idle(2*CPB);
    n_checks++; if (n_acc !== a0) begin n_fail++; $display("FAIL glitch_bytes: got %0d, expected 0", n_acc - a0); end
    n_checks++; if (n_fe + n_ov !== f0 + o0) begin n_fail++; $display("FAIL glitch_err: got %0d pulses, expected 0", n_fe + n_ov - f0 - o0); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b, expected 0", rx_valid); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b, expected 0", rx_busy); end
  endtask

  task automatic test_framing;
    int a0, f0, o0;
    a0 = n_acc; f0 = n_fe; o0 = n_ov;
    rx_ready = 1'b1;
    send_byte(8'hF8, 1'b0);
    for (int i = 0; i < 5; i++) bit_time(1'b0);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL fe_busy_break: got %b, expected 1", rx_busy); end
    idle(2*CPB);
    sb.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    idle(2*CPB);
    n_checks++; if (n_fe - f0 !== 1) begin n_fail++; $display("FAIL fe_pulses: got %0d, expected 1", n_fe - f0); end
    n_checks++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL fe_bytes: got %0d, expected 1", n_acc - a0); end
    n_checks++; if (n_ov !== o0) begin n_fail++; $display("FAIL fe_ov: got %0d pulses, expected 0", n_ov - o0); end
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL fe_left: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_overrun;
    int o0;
    o0 = n_ov;
    rx_ready = 1'b0;
    sb.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(CPB);
    n_checks++; if (n_ov - o0 !== 1) begin n_fail++; $display("FAIL ov_pulses: got %0d, expected 1", n_ov - o0); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ov_valid: got %b, expected 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ov_data: got %h, expected 11", rx_data); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ov_drain: got %b, expected 0", rx_valid); end
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL ov_left: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_ready_on_delivery;
    int o0;
    rx_ready = 1'b0;
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(CPB);
    n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL rod_pend: got %h, expected 55", rx_data); end
    o0 = n_ov;
    sb.push_back(8'h7F);
    fork
      send_byte(8'h7F, 1'b1);
      begin
        repeat (306) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(CPB);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rod_valid: got %b, expected 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h7F) begin n_fail++; $display("FAIL rod_data: got %h, expected 7f", rx_data); end
    n_checks++; if (n_ov !== o0) begin n_fail++; $display("FAIL rod_ov: got %0d pulses, expected 0", n_ov - o0); end
    n_checks++; if (sb.size() !== 1) begin n_fail++; $display("FAIL rod_pop: got %0d pending, expected 1", sb.size()); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rod_drain: got %b, expected 0", rx_valid); end
  endtask

  task automatic test_reset_midbyte;
    int a0;
    rx_ready = 1'b0;
    send_byte(8'h33, 1'b1);
    idle(CPB);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rmb_pend: got %b, expected 1", rx_valid); end
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (5*CPB + 10) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_async_valid: got %b, expected 0", rx_valid); end
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL rmb_async_busy: got %b, expected 1", rx_busy); end
      end
    join
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rmb_data: got %h, expected 00", rx_data); end
    n_checks++; if (rx_framing_err !== 1'b0 || rx_overrun !== 1'b0) begin
      n_fail++; $display("FAIL rmb_err: got fe=%b ov=%b, expected 0 0", rx_framing_err, rx_overrun);
    end
    idle(4);
    rst = 1'b0;
    idle(2*CPB);
    a0 = n_acc;
    rx_ready = 1'b1;
    sb.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    idle(2*CPB);
    n_checks++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL rmb_bytes: got %0d, expected 1", n_acc - a0); end
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL rmb_left: got %0d pending, expected 0", sb.size()); end
    n_checks++; if (rx_data !== 8'h0F) begin n_fail++; $display("FAIL rmb_last: got %h, expected 0f", rx_data); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_overrun;
    test_ready_on_delivery;
    test_reset_midbyte;
    n_checks++;
    if (n_both !== 0) begin n_fail++; $display("FAIL err_exclusive: got %0d overlaps, expected 0", n_both); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
